// File: rtl/uart_tx_arb_pkg.sv
// Shared definitions for the UART TX FIFO write-port arbiter:
// FSM encodings and a constant-width helper.
package uart_tx_arb_pkg;

  typedef enum logic [0:0] {
    ARB_IDLE = 1'b0,
    ARB_LOCK = 1'b1
  } arb_state_e;

  // Bits needed to index 'value' distinct items; never returns less than 1.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      r = r + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/uart_tx_arb_rr_pick.sv
// Round-robin pick: first set request found scanning upward from the
// index just after the previous winner, wrapping at NUM_REQ.
module rr_pick
  import uart_tx_arb_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]        req_i,
  input  logic [clog2(NUM_REQ)-1:0] last_grant_i,
  output logic                      any_o,
  output logic [clog2(NUM_REQ)-1:0] idx_o
);

  localparam int IW = clog2(NUM_REQ);

  // Scan last_grant+1 .. last_grant+NUM_REQ (mod NUM_REQ); first hit wins.
  always_comb begin
    int j;
    logic [IW-1:0] jj;
    any_o = 1'b0;
    idx_o = '0;
    j     = 0;
    jj    = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      j = int'(last_grant_i) + k;
      if (j >= NUM_REQ) begin
        j = j - NUM_REQ;
      end
      jj = IW'(j);
      if (!any_o && req_i[jj]) begin
        any_o = 1'b1;
        idx_o = jj;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter sharing the UART TX FIFO write port among NUM_REQ
// valid/ready requesters. A grant is held for a whole packet so bytes
// from different sources never interleave; long or stalled packets are
// cut by a burst limit or an idle timeout.
//
//  state    | meaning
//  ---------+-------------------------------------------------------------
//  ARB_IDLE | no owner; pick next requester round-robin (no beat moves)
//  ARB_LOCK | grant_id owns the FIFO port until last/burst limit/timeout
module uart_tx_arb
  import uart_tx_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 16,
  parameter int MAX_BURST  = 16,
  parameter int IDLE_TO    = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          arb_en,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_last,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          full_tx,
  output logic                          wr_en,
  output logic [DATA_WIDTH-1:0]         tx_din_fifo,
  output logic [clog2(NUM_REQ)-1:0]     grant_id,
  output logic                          busy,
  output logic                          burst_cut
);

  localparam int IW = clog2(NUM_REQ);
  localparam int BW = clog2(MAX_BURST + 1);
  localparam int TW = clog2(IDLE_TO + 1);

  arb_state_e            state_q, state_d;
  logic [IW-1:0]         grant_id_q, grant_id_d;
  logic [IW-1:0]         last_grant_q, last_grant_d;
  logic [BW-1:0]         beat_cnt_q, beat_cnt_d;
  logic [TW-1:0]         idle_cnt_q, idle_cnt_d;
  logic                  burst_cut_q, burst_cut_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;

  logic                  pick_any;
  logic [IW-1:0]         pick_idx;
  logic                  owner_valid;
  logic                  owner_last;
  logic [DATA_WIDTH-1:0] owner_data;
  logic                  drop;

  rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_pick (
    .req_i        (req_valid),
    .last_grant_i (last_grant_q),
    .any_o        (pick_any),
    .idx_o        (pick_idx)
  );

  // Select the current owner's handshake signals and payload.
  always_comb begin
    owner_valid = 1'b0;
    owner_last  = 1'b0;
    owner_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_id_q == IW'(i)) begin
        owner_valid = req_valid[i];
        owner_last  = req_last[i];
        owner_data  = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Next-state logic, counters and the combinational FIFO write strobe.
  always_comb begin
    state_d      = state_q;
    grant_id_d   = grant_id_q;
    last_grant_d = last_grant_q;
    beat_cnt_d   = beat_cnt_q;
    idle_cnt_d   = idle_cnt_q;
    burst_cut_d  = 1'b0;
    dout_d       = dout_q;
    req_ready    = '0;
    wr_en        = 1'b0;
    drop         = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (arb_en && pick_any) begin
          grant_id_d = pick_idx;
          beat_cnt_d = '0;
          idle_cnt_d = '0;
          state_d    = ARB_LOCK;
        end
      end
      ARB_LOCK: begin
        req_ready[grant_id_q] = !full_tx;
        if (owner_valid && !full_tx) begin
          wr_en      = 1'b1;
          dout_d     = owner_data;
          beat_cnt_d = beat_cnt_q + BW'(1);
          idle_cnt_d = '0;
          // A natural end of packet wins over the burst limit on the same beat.
          if (owner_last) begin
            drop = 1'b1;
          end else if (beat_cnt_q == BW'(MAX_BURST - 1)) begin
            drop        = 1'b1;
            burst_cut_d = 1'b1;
          end
        end else if (!owner_valid) begin
          if (idle_cnt_q == TW'(IDLE_TO - 1)) begin
            drop        = 1'b1;
            burst_cut_d = 1'b1;
          end else begin
            idle_cnt_d = idle_cnt_q + TW'(1);
          end
        end else begin
          // Stalled by a full FIFO with valid held: not idle, never times out.
          idle_cnt_d = '0;
        end
        if (drop) begin
          state_d      = ARB_IDLE;
          last_grant_d = grant_id_q;
          beat_cnt_d   = '0;
          idle_cnt_d   = '0;
        end
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  assign tx_din_fifo = dout_d;
  assign grant_id    = grant_id_q;
  assign busy        = (state_q == ARB_LOCK);
  assign burst_cut   = burst_cut_q;

  // State register with synchronous reset; last_grant resets so index 0 wins first.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ARB_IDLE;
      grant_id_q   <= '0;
      last_grant_q <= IW'(NUM_REQ - 1);
      beat_cnt_q   <= '0;
      idle_cnt_q   <= '0;
      burst_cut_q  <= 1'b0;
      dout_q       <= '0;
    end else begin
      state_q      <= state_d;
      grant_id_q   <= grant_id_d;
      last_grant_q <= last_grant_d;
      beat_cnt_q   <= beat_cnt_d;
      idle_cnt_q   <= idle_cnt_d;
      burst_cut_q  <= burst_cut_d;
      dout_q       <= dout_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_arb.sv
// Scoreboard bench for uart_tx_arb: directed packets are queued per
// requester, expected FIFO writes / burst cuts / status snapshots are
// queued alongside, and a negedge monitor pops and compares.
module tb_uart_tx_arb;

  localparam int NR = 4;
  localparam int DW = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic            arb_en;
  logic [NR-1:0]   req_valid;
  logic [NR-1:0]   req_last;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]   req_ready;
  logic            full_tx;
  logic            wr_en;
  logic [DW-1:0]   tx_din_fifo;
  logic [1:0]      grant_id;
  logic            busy;
  logic            burst_cut;

  always #5 clk = ~clk;

  uart_tx_arb #(
    .NUM_REQ    (NR),
    .DATA_WIDTH (DW),
    .MAX_BURST  (16),
    .IDLE_TO    (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .arb_en      (arb_en),
    .req_valid   (req_valid),
    .req_last    (req_last),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .full_tx     (full_tx),
    .wr_en       (wr_en),
    .tx_din_fifo (tx_din_fifo),
    .grant_id    (grant_id),
    .busy        (busy),
    .burst_cut   (burst_cut)
  );

  // Status word: {busy, wr_en, req_ready[3:0], burst_cut, grant_id[1:0], tx_din_fifo}
  logic [24:0] status;
  assign status = {busy, wr_en, req_ready, burst_cut, grant_id, tx_din_fifo};

  typedef struct {
    string       name;
    logic [24:0] mask;
    logic [24:0] val;
  } snap_t;

  // Requester beat entry: [24:17] idle gap before this beat, [16] last, [15:0] data
  logic [24:0] rq [NR][$];
  int unsigned wait_c [NR];
  logic [NR-1:0] acc;
  logic [17:0] exp_wr[$];
  logic [1:0]  exp_cut[$];
  snap_t       exp_snap[$];
  int          n_cmp;
  int          n_bad;
  int          wr_total;
  int          cyc;
  logic        gap_chk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: scoreboard pops on every FIFO write, burst cut and queued snapshot.
  initial begin
    int  prev;
    bit  have_prev;
    snap_t s;
    prev      = 0;
    have_prev = 0;
    cyc       = 0;
    wr_total  = 0;
    acc       = '0;
    forever begin
      @(negedge clk);
      cyc++;
      acc = req_valid & req_ready;
      if (exp_snap.size() > 0) begin
        s = exp_snap.pop_front();
        chk(s.name, 32'(status & s.mask), 32'(s.val & s.mask));
      end
      if (!rst) begin
        if (wr_en) begin
          wr_total++;
          if (exp_wr.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL wr_unexpected: got id %0d data 0x%0h expected no write", grant_id, tx_din_fifo);
          end else begin
            chk("wr_beat", 32'({grant_id, tx_din_fifo}), 32'(exp_wr.pop_front()));
          end
          if (gap_chk) begin
            if (have_prev) chk("grant_spacing", 32'(cyc - prev), 32'd2);
            have_prev = 1;
            prev      = cyc;
          end
        end
        if (burst_cut) begin
          if (exp_cut.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL cut_unexpected: got burst_cut id %0d expected none", grant_id);
          end else begin
            chk("burst_cut_owner", 32'(grant_id), 32'(exp_cut.pop_front()));
          end
        end
      end
      if (!gap_chk) have_prev = 0;
    end
  end

  // Requester models: present queue heads, pop on acceptance, honour gaps.
  initial begin
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    for (int i = 0; i < NR; i++) wait_c[i] = 0;
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < NR; i++) begin
        if (acc[i] && rq[i].size() > 0) begin
          void'(rq[i].pop_front());
          if (rq[i].size() > 0) wait_c[i] = int'(rq[i][0][24:17]);
        end else if (wait_c[i] > 0) begin
          wait_c[i]--;
        end
        if (rq[i].size() > 0 && wait_c[i] == 0) begin
          req_valid[i]          = 1'b1;
          req_last[i]           = rq[i][0][16];
          req_data[i*DW +: DW]  = rq[i][0][15:0];
        end else begin
          req_valid[i]          = 1'b0;
          req_last[i]           = 1'b0;
          req_data[i*DW +: DW]  = '0;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic push(input int r, input logic [15:0] d, input bit last, input int gap);
    rq[r].push_back({8'(gap), last, d});
  endtask

  task automatic expw(input int r, input logic [15:0] d);
    exp_wr.push_back({2'(r), d});
  endtask

  function automatic bit reqs_pending();
    bit p;
    p = 0;
    for (int i = 0; i < NR; i++) if (rq[i].size() > 0) p = 1;
    return p;
  endfunction

  task automatic drain(input string name, input int budget);
    int n;
    n = 0;
    while ((exp_wr.size() > 0 || exp_cut.size() > 0 || reqs_pending()) && n < budget) begin
      step();
      n++;
    end
    repeat (12) step();
    n_cmp++;
    if (n >= budget) begin
      n_bad++;
      $display("FAIL %s_timeout: got %0d cycles expected under %0d", name, n, budget);
    end
    chk({name, "_leftover"}, 32'(exp_wr.size() + exp_cut.size()), 32'd0);
  endtask

  task automatic wait_wr(input string name, input int target, input int budget);
    int n;
    n = 0;
    while (wr_total < target && n < budget) begin
      step();
      n++;
    end
    n_cmp++;
    if (n >= budget) begin
      n_bad++;
      $display("FAIL %s_wait: got %0d writes expected %0d", name, wr_total, target);
    end
  endtask

  initial begin
    int w0;
    n_cmp   = 0;
    n_bad   = 0;
    rst     = 1'b1;
    arb_en  = 1'b1;
    full_tx = 1'b0;
    gap_chk = 1'b0;
    repeat (3) step();
    exp_snap.push_back('{"reset_outputs", 25'h1FFFFFF, 25'h0});
    step();
    rst = 1'b0;
    step();

    // 1: req0 and req2 3-beat packets; req0 first after reset.
    push(0, 16'h11, 0, 0); push(0, 16'h12, 0, 0); push(0, 16'h13, 1, 0);
    push(2, 16'h21, 0, 0); push(2, 16'h22, 0, 0); push(2, 16'h23, 1, 0);
    expw(0, 16'h11); expw(0, 16'h12); expw(0, 16'h13);
    expw(2, 16'h21); expw(2, 16'h22); expw(2, 16'h23);
    w0 = wr_total;
    drain("t1", 100);
    chk("t1_wr_cycles", 32'(wr_total - w0), 32'd6);

    // 2: all four send 1-beat packets; last owner was 2, so 3 leads.
    gap_chk = 1'b1;
    for (int i = 0; i < NR; i++) begin
      push(i, 16'h30 + 16'(i), 1, 0);
      push(i, 16'h40 + 16'(i), 1, 0);
    end
    expw(3, 16'h33); expw(0, 16'h30); expw(1, 16'h31); expw(2, 16'h32);
    expw(3, 16'h43); expw(0, 16'h40); expw(1, 16'h41); expw(2, 16'h42);
    drain("t2", 100);
    gap_chk = 1'b0;

    // 3: req1 20 beats without last; cut after 16, req3 served, req1 resumes then idles out.
    for (int k = 0; k < 20; k++) push(1, 16'h100 + 16'(k), 0, 0);
    for (int k = 0; k < 16; k++) expw(1, 16'h100 + 16'(k));
    expw(3, 16'h301); expw(3, 16'h302);
    for (int k = 16; k < 20; k++) expw(1, 16'h100 + 16'(k));
    exp_cut.push_back(2'd1);
    exp_cut.push_back(2'd1);
    repeat (4) step();
    push(3, 16'h301, 0, 0); push(3, 16'h302, 1, 0);
    drain("t3", 200);

    // 4: FIFO full for 10 cycles mid-packet; owner 2 stalls, data held, no cut.
    for (int k = 0; k < 6; k++) begin
      push(2, 16'h51 + 16'(k), (k == 5), 0);
      expw(2, 16'h51 + 16'(k));
    end
    w0 = wr_total;
    wait_wr("t4", w0 + 3, 50);
    full_tx = 1'b1;
    for (int k = 0; k < 10; k++) begin
      exp_snap.push_back('{"stall_status", 25'h1FBFFFF, 25'h1020053});
      step();
    end
    full_tx = 1'b0;
    drain("t4", 100);

    // 5a: req0 gap of 8 cycles revokes the grant, then re-granted.
    push(0, 16'h61, 0, 0); push(0, 16'h62, 0, 0); push(0, 16'h63, 1, 8);
    expw(0, 16'h61); expw(0, 16'h62); expw(0, 16'h63);
    exp_cut.push_back(2'd0);
    drain("t5a", 100);

    // 5b: req1 gap of 7 cycles keeps the grant.
    push(1, 16'h71, 0, 0); push(1, 16'h72, 1, 7);
    expw(1, 16'h71); expw(1, 16'h72);
    drain("t5b", 100);

    // 6: reset mid-packet, then requester 0 has first priority over 3.
    for (int k = 0; k < 6; k++) begin
      push(1, 16'h81 + 16'(k), (k == 5), 0);
      expw(1, 16'h81 + 16'(k));
    end
    w0 = wr_total;
    wait_wr("t6", w0 + 2, 50);
    rst = 1'b1;
    step();
    exp_snap.push_back('{"post_rst_status", 25'h1FF0000, 25'h0});
    for (int i = 0; i < NR; i++) begin
      rq[i].delete();
      wait_c[i] = 0;
    end
    exp_wr.delete();
    push(3, 16'h93, 1, 0);
    push(0, 16'h90, 1, 0);
    expw(0, 16'h90); expw(3, 16'h93);
    step();
    rst = 1'b0;
    drain("t6", 100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
